// File: rtl/node_eta_decoder.sv
// node_eta_decoder: receive-side inverse of the node_eta encoder.
//
// It tracks the encoder's two state registers (m0, m1) and advances them only
// on accepted beats. Each encoded beat is decoded by subtracting the mask
// term c = m0 & ~m1. A single output register stage provides backpressure.
//
// Ports:
//   clk         clock, all state on rising edge
//   rst         asynchronous active-high reset
//   sync_clear  synchronous restart of mirror state, output stage and counter
//   in_valid    encoded beat present
//   in_ready    decoder can accept a beat
//   in_vec      encoded vector
//   out_valid   decoded beat present
//   out_ready   downstream accepts the decoded beat
//   out_vec     decoded vector
//   beat_count  beats accepted since reset/sync_clear (wraps)
module node_eta_decoder #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sync_clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_vec,
  output logic [CNT_WIDTH-1:0] beat_count
);

  logic [WIDTH-1:0]     m0_q, m0_d;
  logic [WIDTH-1:0]     m1_q, m1_d;
  logic [WIDTH-1:0]     vec_q, vec_d;
  logic                 valid_q, valid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] dec;
  logic             accept;

  assign mask = m0_q & ~m1_q;
  // Modular subtract; the borrow out is intentionally dropped.
  assign dec  = in_vec - mask;

  // rst gates in_ready so no beat is claimed while the mirror is held in reset.
  assign in_ready = !rst && !sync_clear && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    m0_d    = m0_q;
    m1_d    = m1_q;
    vec_d   = vec_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (sync_clear) begin
      // Pending output beat is discarded; out_vec keeps its last value.
      m0_d    = '0;
      m1_d    = '0;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else if (accept) begin
      m0_d    = dec | mask;
      m1_d    = m0_q ^ dec;
      vec_d   = dec;
      valid_d = 1'b1;
      cnt_d   = cnt_q + 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_q    <= '0;
      m1_q    <= '0;
      vec_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      m0_q    <= m0_d;
      m1_q    <= m1_d;
      vec_q   <= vec_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_vec    = vec_q;
  assign beat_count = cnt_q;

endmodule

// File: tb/tb_node_eta_decoder.sv
// Self-checking bench for node_eta_decoder: directed known-vector streams
// (with backpressure, bubbles, sync_clear, mid-stream reset) and a randomized
// round trip against a behavioural node_eta encoder model.
module tb_node_eta_decoder;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          sync_clear;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_vec;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_vec;
  logic [CW-1:0] beat_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] kv_in  [5] = '{16'h0005, 16'h0003, 16'h0011, 16'hFFFF, 16'h0010};
  logic [W-1:0] kv_exp [5] = '{16'h0005, 16'h0003, 16'h0010, 16'hFFFF, 16'hFFFF};

  node_eta_decoder #(
    .WIDTH     (W),
    .CNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sync_clear (sync_clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vec     (in_vec),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vec    (out_vec),
    .beat_count (beat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    sync_clear = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Drives the known-vector stream, optionally stalling the output for
  // stall_len cycles from cycle stall_at, and optionally inserting bubbles.
  task automatic run_kv(input int stall_at, input int stall_len, input bit bubbles);
    int  i   = 0;
    int  cyc = 0;
    bit  ov  = 1'b0;
    bit  v, ordy, rdy, acc;
    while ((i < 5 || ov) && cyc < 40) begin
      v    = (i < 5) && !(bubbles && (cyc % 2 == 1));
      ordy = !(cyc >= stall_at && cyc < stall_at + stall_len);
      in_valid  = v;
      in_vec    = kv_in[(i < 5) ? i : 0];
      out_ready = ordy;
      #1;
      rdy = !ov || ordy;
      check("kv_in_ready", {31'b0, in_ready}, {31'b0, rdy});
      acc = v && rdy;
      tick();
      if (acc) begin
        check("kv_out_vec", {16'b0, out_vec}, {16'b0, kv_exp[i]});
        check("kv_out_valid", {31'b0, out_valid}, 32'd1);
        i++;
        ov = 1'b1;
      end else if (ov && ordy) begin
        ov = 1'b0;
        check("kv_drain", {31'b0, out_valid}, 32'd0);
      end else if (ov) begin
        check("kv_hold_vec", {16'b0, out_vec}, {16'b0, kv_exp[i-1]});
        check("kv_hold_valid", {31'b0, out_valid}, 32'd1);
      end
      cyc++;
    end
    in_valid = 1'b0;
    if (cyc >= 40) check("kv_timeout", 32'd0, 32'd1);
    check("kv_beat_count", {24'b0, beat_count}, 32'd5);
  endtask

  // Round trip against an encoder model that emits x + (e0 & ~e1).
  task automatic run_roundtrip();
    logic [W-1:0] e0 = '0, e1 = '0, x = '0, c;
    bit  have = 1'b0, ov = 1'b0, v, ordy, rdy;
    int  acc_n = 0, cyc = 0;
    do_reset();
    while (acc_n < 1000 && cyc < 8000) begin
      if (!have) begin
        x = W'($urandom);
        have = 1'b1;
      end
      c    = e0 & ~e1;
      v    = ($urandom_range(3) != 0);
      ordy = ($urandom_range(1) != 0);
      in_valid  = v;
      in_vec    = x + c;
      out_ready = ordy;
      #1;
      rdy = !ov || ordy;
      if (cyc < 50 || !rdy) check("rt_in_ready", {31'b0, in_ready}, {31'b0, rdy});
      tick();
      if (v && rdy) begin
        e1 = e0 ^ x;
        e0 = x | c;
        have = 1'b0;
        acc_n++;
        ov = 1'b1;
        check("rt_out_vec", {16'b0, out_vec}, {16'b0, x});
        check("rt_beat_count", {24'b0, beat_count}, acc_n % 256);
      end else if (ov && ordy) begin
        ov = 1'b0;
      end
      if (cyc < 50) check("rt_out_valid", {31'b0, out_valid}, {31'b0, ov});
      cyc++;
    end
    in_valid = 1'b0;
    if (acc_n < 1000) check("rt_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    sync_clear = 1'b0;
    in_valid = 1'b0;
    in_vec = '0;
    out_ready = 1'b1;
    tick();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_vec", {16'b0, out_vec}, 32'd0);
    check("rst_beat_count", {24'b0, beat_count}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Plain stream, then backpressure, then bubbles.
    run_kv(99, 0, 1'b0);
    do_reset();
    run_kv(2, 3, 1'b0);
    do_reset();
    run_kv(99, 0, 1'b1);

    // sync_clear after three beats, with a beat offered on the clear cycle.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_vec = kv_in[i];
      tick();
    end
    check("sc_pre_count", {24'b0, beat_count}, 32'd3);
    sync_clear = 1'b1;
    in_vec = kv_in[3];
    #1;
    check("sc_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    sync_clear = 1'b0;
    in_valid = 1'b0;
    #1;
    check("sc_out_valid", {31'b0, out_valid}, 32'd0);
    check("sc_beat_count", {24'b0, beat_count}, 32'd0);
    run_kv(99, 0, 1'b0);

    // Asynchronous reset while an output beat is pending.
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_vec = kv_in[0];
    tick();
    in_valid = 1'b0;
    check("mid_pre_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_vec", {16'b0, out_vec}, 32'd0);
    check("mid_rst_count", {24'b0, beat_count}, 32'd0);
    check("mid_rst_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("mid_post_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("mid_post_valid", {31'b0, out_valid}, 32'd0);

    run_roundtrip();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/node_eta_decoder.md
Name: node_eta_decoder

Overview:
- Receive-side inverse of the node_eta encoder.
- Accepts the encoded vector stream over a valid/ready handshake and rebuilds the original input vectors.
- Keeps a mirror of the encoder's two state registers and subtracts the mirrored mask term from each encoded beat.
- Sits at the consumer end of a node_eta link; adds one output register stage with backpressure and a resync control.

Parameters:
WIDTH, 16, width of encoded and decoded vectors
CNT_WIDTH, 16, width of accepted-beat counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
sync_clear  input  1  synchronous restart of mirror state (pairs with an encoder reset)
in_valid  input  1  encoded beat present
in_ready  output  1  decoder can accept a beat
in_vec  input  WIDTH  encoded vector (encoder output_vec)
out_valid  output  1  decoded beat present
out_ready  input  1  downstream accepts the decoded beat
out_vec  output  WIDTH  decoded vector (recovered encoder input_vec)
beat_count  output  CNT_WIDTH  number of beats accepted since reset/sync_clear

Behaviour:
- Mirror registers m0 and m1, each WIDTH bits, reset to 0.
- Mask term: c = m0 & ~m1 (combinational).
- Each accepted beat corresponds to exactly one encoder cycle, counted from the encoder's reset. The upstream link must not drop or duplicate beats.
- Accept condition: in_valid & in_ready.
- in_ready = !rst & !sync_clear & (!out_valid | out_ready). This gives a one-deep pipeline with full throughput when out_ready = 1.
- On accept:
  - d = (in_vec - c) mod 2^WIDTH. Unsigned; the borrow is discarded.
  - m0 <= d | c
  - m1 <= m0 ^ d (uses the pre-update m0)
  - out_vec <= d; out_valid <= 1
  - beat_count <= beat_count + 1, wrapping at 2^CNT_WIDTH
- Latency: exactly 1 cycle from accept to out_valid = 1 carrying that beat.
- Output hold: while out_valid & !out_ready, out_vec and out_valid stay stable and no beat is accepted.
- Output drain: on out_valid & out_ready with no new accept in the same cycle, out_valid <= 0. out_vec keeps its last value.
- Simultaneous drain and accept in one cycle: out_valid stays 1 and out_vec takes the new d.
- When no beat is accepted, m0, m1 and beat_count hold. The mirror advances only on accepts, never on idle cycles.
- sync_clear (synchronous, priority over everything except rst):
  - Next state: m0 = 0, m1 = 0, out_valid = 0, beat_count = 0.
  - in_ready = 0 that cycle, so in_vec is not consumed.
  - Any pending output beat is discarded.
- Reset values (rst = 1, asynchronous): m0 = 0, m1 = 0, out_vec = 0, out_valid = 0, beat_count = 0; in_ready = 0 while rst is high.
- Reset mid-stream: the in-flight output beat is lost and the mirror restarts from zero, so the encoder must also be reset.
- First cycle after rst deasserts: in_ready = 1.
- beat_count wrap: 2^CNT_WIDTH - 1 plus one accept gives 0, with no flag.

Test Plan:
- Reset/idle: assert rst mid-operation with out_valid = 1 -> out_valid, out_vec, beat_count drop to 0 immediately. After deassert, in_ready = 1 and out_valid stays 0 with in_valid = 0.
- Known-vector decode, WIDTH = 16, out_ready = 1: in_vec 0x0005, 0x0003, 0x0011, 0xFFFF, 0x0010 on consecutive cycles -> out_vec 0x0005, 0x0003, 0x0010, 0xFFFF, 0xFFFF, each one cycle later. beat_count = 5. The last beat exercises subtract wrap (c = 0x0011).
- Backpressure: same stream with out_ready low for 3 cycles after the 2nd output -> out_vec holds 0x0003 and in_ready = 0 for those cycles. On release the remaining outputs match the above exactly, with no skip or duplicate.
- Bubbles: insert in_valid = 0 gaps between the beats above -> identical output values. The mirror does not advance during gaps.
- sync_clear: after 3 beats, pulse sync_clear with in_valid = 1 -> that beat is not accepted, out_valid = 0, beat_count = 0. Then in_vec 0x0005, 0x0003 -> outputs 0x0005, 0x0003.
- Round trip: node_eta encoder driven by random vectors (1000 cycles, both reset together), decoder fed every encoder cycle with random out_ready -> decoded sequence equals the encoder input sequence in order.
